vga_apb_pixel_ctrl: RTL

- APB slave for the VGA subsystem that queues pixel-write commands (x, y, color) in a parametrised FIFO.
- Drains the FIFO to the frame-buffer write port through a valid/ready handshake.
- Adds multi-bit color, auto-increment raster addressing, FIFO status/flush, and APB wait-states on back-pressure.
- Sits between the APB interconnect and the VGA frame-buffer/memory wrapper.

---
 rtl/vga_apb_pixel_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_apb_pixel_ctrl.sv
// APB slave that queues pixel-write commands (x, y, color) in a FIFO and
// drains them to the frame-buffer write port over a valid/ready handshake.
module vga_apb_pixel_ctrl #(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned X_WIDTH        = 11,
   parameter int unsigned Y_WIDTH        = 11,
   parameter int unsigned COLOR_WIDTH    = 12,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned H_RES          = 640,
   parameter int unsigned V_RES          = 480
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
   input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
   input  logic                      apb_pwrite_i,
   input  logic                      apb_psel_i,
   input  logic                      apb_penable_i,
   output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
   output logic                      apb_pready_o,
   output logic                      apb_pslverr_o,
   output logic                      pix_valid_o,
   input  logic                      pix_ready_i,
   output logic [X_WIDTH-1:0]        pix_x_o,
   output logic [Y_WIDTH-1:0]        pix_y_o,
   output logic [COLOR_WIDTH-1:0]    pix_color_o
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = X_WIDTH + Y_WIDTH + COLOR_WIDTH;

   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_X      = APB_ADDR_WIDTH'('h00);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_Y      = APB_ADDR_WIDTH'('h04);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_COLOR  = APB_ADDR_WIDTH'('h08);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL   = APB_ADDR_WIDTH'('h0C);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_PUSH   = APB_ADDR_WIDTH'('h10);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_PIXEL  = APB_ADDR_WIDTH'('h14);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_STATUS = APB_ADDR_WIDTH'('h18);

   // software-visible registers
   logic [X_WIDTH-1:0]        x_q;
   logic [Y_WIDTH-1:0]        y_q;
   logic [COLOR_WIDTH-1:0]    color_q;
   logic                      autoinc_q;

   // command FIFO
   logic [ENTRY_W-1:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q;
   logic [PTR_W-1:0]          rd_ptr_q;
   logic [LVL_W-1:0]          level_q;

   // APB response registers
   logic                      pready_q;
   logic                      pslverr_q;
   logic [APB_DATA_WIDTH-1:0] prdata_q;

   // decode and handshake helpers
   logic sel_x_c, sel_y_c, sel_color_c, sel_ctrl_c, sel_push_c, sel_pixel_c, sel_status_c;
   logic access_c, err_c, push_req_c, commit_c, wr_en_c, push_c, pop_c, flush_c;
   logic empty_c, full_c, x_wrap_c;
   logic [COLOR_WIDTH-1:0]    push_color_c;
   logic [X_WIDTH-1:0]        x_inc_c;
   logic [Y_WIDTH-1:0]        y_inc_c;
   logic [APB_DATA_WIDTH-1:0] rdata_c;
   logic                      unused_pwdata_c;

   assign unused_pwdata_c = ^apb_pwdata_i;

   assign sel_x_c      = (apb_paddr_i == ADDR_X);
   assign sel_y_c      = (apb_paddr_i == ADDR_Y);
   assign sel_color_c  = (apb_paddr_i == ADDR_COLOR);
   assign sel_ctrl_c   = (apb_paddr_i == ADDR_CTRL);
   assign sel_push_c   = (apb_paddr_i == ADDR_PUSH);
   assign sel_pixel_c  = (apb_paddr_i == ADDR_PIXEL);
   assign sel_status_c = (apb_paddr_i == ADDR_STATUS);

   assign empty_c = (level_q == '0);
   assign full_c  = (level_q == LVL_W'(FIFO_DEPTH));

   // A push-type write waits while the FIFO is full; everything else commits at once.
   assign access_c   = apb_psel_i & apb_penable_i & ~pready_q;
   assign err_c      = ~(sel_x_c | sel_y_c | sel_color_c | sel_ctrl_c | sel_push_c |
                         sel_pixel_c | sel_status_c) | (apb_pwrite_i & sel_status_c);
   assign push_req_c = apb_pwrite_i & (sel_push_c | sel_pixel_c);
   assign commit_c   = access_c & ~(push_req_c & full_c);
   assign wr_en_c    = commit_c & apb_pwrite_i & ~err_c;
   assign push_c     = wr_en_c & (sel_push_c | sel_pixel_c);
   assign flush_c    = wr_en_c & sel_ctrl_c & apb_pwdata_i[1];
   assign pop_c      = ~empty_c & pix_ready_i;

   assign push_color_c = sel_pixel_c ? apb_pwdata_i[COLOR_WIDTH-1:0] : color_q;

   // raster advance: x wraps at (or beyond) the last column, carrying into y
   assign x_wrap_c = (x_q >= X_WIDTH'(H_RES - 32'd1));
   assign x_inc_c  = x_wrap_c ? '0 : x_q + X_WIDTH'(1);
   assign y_inc_c  = !x_wrap_c ? y_q :
                     (y_q == Y_WIDTH'(V_RES - 32'd1)) ? '0 : y_q + Y_WIDTH'(1);

   // read-data mux; unused bits and write-only addresses read as zero
   always_comb begin
      rdata_c = '0;
      if (sel_x_c)     rdata_c[X_WIDTH-1:0]     = x_q;
      if (sel_y_c)     rdata_c[Y_WIDTH-1:0]     = y_q;
      if (sel_color_c) rdata_c[COLOR_WIDTH-1:0] = color_q;
      if (sel_ctrl_c)  rdata_c[0]               = autoinc_q;
      if (sel_status_c) begin
         rdata_c[0]    = empty_c;
         rdata_c[1]    = full_c;
         rdata_c[15:8] = 8'(level_q);
      end
   end

   // register writes and post-push auto-increment
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         x_q       <= '0;
         y_q       <= '0;
         color_q   <= '0;
         autoinc_q <= 1'b0;
      end else if (wr_en_c) begin
         if (sel_x_c)     x_q       <= apb_pwdata_i[X_WIDTH-1:0];
         if (sel_y_c)     y_q       <= apb_pwdata_i[Y_WIDTH-1:0];
         if (sel_color_c) color_q   <= apb_pwdata_i[COLOR_WIDTH-1:0];
         if (sel_ctrl_c)  autoinc_q <= apb_pwdata_i[0];
         if (sel_pixel_c) color_q   <= apb_pwdata_i[COLOR_WIDTH-1:0];
         if (push_c && autoinc_q) begin
            x_q <= x_inc_c;
            y_q <= y_inc_c;
         end
      end
   end

   // APB response: one-cycle pready, prdata/pslverr only alongside it
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         pready_q  <= commit_c;
         pslverr_q <= commit_c & err_c;
         prdata_q  <= (commit_c & ~apb_pwrite_i & ~err_c) ? rdata_c : '0;
      end
   end

   // FIFO storage; cleared in reset so the head outputs start at zero
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else if (push_c) begin
         mem_q[wr_ptr_q] <= {x_q, y_q, push_color_c};
      end
   end

   // FIFO pointers and level; flush wins over a same-cycle pop
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_c) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   assign apb_prdata_o  = prdata_q;
   assign apb_pready_o  = pready_q;
   assign apb_pslverr_o = pslverr_q;
   assign pix_valid_o   = ~empty_c;
   assign {pix_x_o, pix_y_o, pix_color_o} = mem_q[rd_ptr_q];

endmodule
